// File: rtl/mdu_div_iter.sv
// Multicycle radix-2 restoring divider for the EX stage: signed/unsigned per op,
// one quotient bit per cycle, with annul, divide-by-zero flag and busy indication.
module mdu_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   rem_fix, quo_fix;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // One restoring step; quo_q doubles as the dividend shift register.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
    rem_step  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix   = neg_quo_q ? (~quo_step + WIDTH'(1)) : quo_step;
    rem_fix   = neg_rem_q ? (~rem_step + WIDTH'(1)) : rem_step;
    abs_a     = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    abs_b     = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    dz_d      = dz_q;
    ready_d   = 1'b0;
    busy_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dz_d      = 1'b0;
          neg_quo_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d = signed_i & opdata1_i[WIDTH-1];
          if (opdata2_i == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            dz_d     = 1'b1;
            ready_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dz_q      <= dz_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Bench for mdu_div_iter: a 32-bit and an 8-bit instance checked every cycle
// against a transaction-level model, plus directed literal cases.
module tb_mdu_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        st0 = 0, sg0 = 0, an0 = 0;
  logic [31:0] a0 = 0, b0 = 0;
  logic [63:0] res0;
  logic        rdy0, bsy0, dz0;

  logic        st1 = 0, sg1 = 0, an1 = 0;
  logic [7:0]  a1 = 0, b1 = 0;
  logic [15:0] res1;
  logic        rdy1, bsy1, dz1;

  mdu_div_iter #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start_i(st0), .signed_i(sg0), .opdata1_i(a0), .opdata2_i(b0),
    .annul_i(an0), .result_o(res0), .ready_o(rdy0), .busy_o(bsy0), .div_zero_o(dz0)
  );

  mdu_div_iter #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start_i(st1), .signed_i(sg1), .opdata1_i(a1), .opdata2_i(b1),
    .annul_i(an1), .result_o(res1), .ready_o(rdy1), .busy_o(bsy1), .div_zero_o(dz1)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 dividing, 2 result cycle
  int          ph[2]     = '{0, 0};
  int          left[2]   = '{0, 0};
  logic [63:0] m_res[2]  = '{64'd0, 64'd0};
  logic [63:0] pend[2]   = '{64'd0, 64'd0};
  logic        m_rdy[2]  = '{1'b0, 1'b0};
  logic        m_busy[2] = '{1'b0, 1'b0};
  logic        m_dz[2]   = '{1'b0, 1'b0};

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input int w);
    longint m, sa, sb, q, r;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sgn) begin
      if (sa[w-1]) sa = sa - (longint'(1) << w);
      if (sb[w-1]) sb = sb - (longint'(1) << w);
    end
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & m) << w) | (q & m));
  endfunction

  task automatic model_step(input int i, input logic st, input logic an, input logic sg,
                            input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mask;
    mask = 32'((longint'(1) << w) - 1);
    case (ph[i])
      2: begin ph[i] = 0; m_rdy[i] = 1'b0; end
      1: begin
        if (an) begin
          ph[i] = 0; m_busy[i] = 1'b0;
        end else begin
          left[i]--;
          if (left[i] == 0) begin
            ph[i] = 2; m_busy[i] = 1'b0; m_rdy[i] = 1'b1; m_res[i] = pend[i];
          end
        end
      end
      default: begin
        if (st && !an) begin
          if ((b & mask) == 0) begin
            ph[i] = 2; m_rdy[i] = 1'b1; m_res[i] = 64'd0; m_dz[i] = 1'b1;
          end else begin
            ph[i] = 1; m_busy[i] = 1'b1; m_dz[i] = 1'b0; left[i] = w;
            pend[i] = ref_div(a, b, sg, w);
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; left[i] = 0; m_res[i] = 64'd0; pend[i] = 64'd0;
        m_rdy[i] = 1'b0; m_busy[i] = 1'b0; m_dz[i] = 1'b0;
      end
    end else begin
      model_step(0, st0, an0, sg0, a0, b0, 32);
      model_step(1, st1, an1, sg1, {24'd0, a1}, {24'd0, b1}, 8);
    end
  end

  // Every-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    check("rdy32", 64'(rdy0), 64'(m_rdy[0]));
    check("busy32", 64'(bsy0), 64'(m_busy[0]));
    check("dz32", 64'(dz0), 64'(m_dz[0]));
    check("res32", res0, m_res[0]);
    check("rdy8", 64'(rdy1), 64'(m_rdy[1]));
    check("busy8", 64'(bsy1), 64'(m_busy[1]));
    check("dz8", 64'(dz1), 64'(m_dz[1]));
    check("res8", 64'(res1), m_res[1]);
  end

  function automatic logic g_rdy(input int i);
    return (i == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic g_bsy(input int i);
    return (i == 0) ? bsy0 : bsy1;
  endfunction
  function automatic logic g_dz(input int i);
    return (i == 0) ? dz0 : dz1;
  endfunction
  function automatic logic [63:0] g_res(input int i);
    return (i == 0) ? res0 : 64'(res1);
  endfunction

  task automatic drv(input int i, input logic st, input logic sg, input logic an,
                     input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      st0 = st; sg0 = sg; an0 = an; a0 = a; b0 = b;
    end else begin
      st1 = st; sg1 = sg; an1 = an; a1 = a[7:0]; b1 = b[7:0];
    end
  endtask

  // Directed op with literal expectations; called at posedge+1 with the DUT idle
  task automatic do_op(input int i, input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic [63:0] lit, input int lat_exp, input logic dz_exp);
    int lat, nbusy;
    drv(i, 1'b1, sg, 1'b0, a, b);
    @(posedge clk); #1;
    drv(i, 1'b0, sg, 1'b0, a, b);
    lat = 1;
    nbusy = 0;
    while (!g_rdy(i) && lat < 200) begin
      if (g_bsy(i)) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_res"}, g_res(i), lit);
    check({name, "_dz"}, 64'(g_dz(i)), 64'(dz_exp));
    check({name, "_busycyc"}, 64'(nbusy), 64'((lat_exp == 1) ? 0 : lat_exp - 1));
    @(posedge clk); #1;
  endtask

  task automatic rand_op(input int i, input int w);
    logic [31:0] a, b;
    logic        sg, do_an;
    int          r, ak;
    a  = $urandom;
    r  = $urandom_range(0, 9);
    sg = 1'($urandom_range(0, 1));
    case (r)
      0: b = 32'd0;
      1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'd1 << (w - 1); end
      2: b = 32'($urandom_range(1, 15));
      default: b = $urandom;
    endcase
    do_an = ($urandom_range(0, 7) == 0);
    ak    = $urandom_range(0, w);
    drv(i, 1'b1, sg, 1'b0, a, b);
    @(posedge clk); #1;
    for (int k = 0; k < 200; k++) begin
      if (ph[i] == 0) break;
      if (ph[i] == 1)
        drv(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), do_an && (k == ak),
            $urandom, $urandom);
      else
        drv(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
    end
    drv(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("rand_back_to_idle", 64'(ph[i] == 0), 64'd1);
  endtask

  initial begin
    int nrdy, t0;
    int pulses[$];

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res32", res0, 64'd0);
    check("rst_rdy32", 64'(rdy0), 64'd0);
    check("rst_busy32", 64'(bsy0), 64'd0);
    check("rst_dz32", 64'(dz0), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, "u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0);
    do_op(0, "s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    do_op(0, "s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b0);
    do_op(0, "s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0);
    do_op(0, "u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 33, 1'b0);
    do_op(0, "divzero", 32'h1234, 32'd0, 1'b0, 64'd0, 1, 1'b1);
    do_op(0, "u9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 1'b0);

    // Annul during iteration 10 of a second divide
    do_op(0, "u100_7b", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0);
    drv(0, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0, 32'd50, 32'd5);
    repeat (10) begin @(posedge clk); #1; end
    an0 = 1'b1;
    @(posedge clk); #1;
    an0 = 1'b0;
    check("annul_busy", 64'(bsy0), 64'd0);
    check("annul_res", res0, 64'h00000002_0000000E);
    nrdy = 0;
    repeat (40) begin @(posedge clk); #1; if (rdy0) nrdy++; end
    check("annul_no_ready", 64'(nrdy), 64'd0);

    // Async reset in the middle of a divide
    drv(0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_res", res0, 64'd0);
    check("midrst_busy", 64'(bsy0), 64'd0);
    check("midrst_rdy", 64'(rdy0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1, "u8_ff_10", 32'hFF, 32'h10, 1'b0, 64'h0F0F, 9, 1'b0);
    do_op(1, "s8_min_m1", 32'h80, 32'hFF, 1'b1, 64'h0080, 9, 1'b0);

    // Start held high: one result every WIDTH+2 cycles
    drv(1, 1'b1, 1'b0, 1'b0, 32'd200, 32'd7);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rdy1) pulses.push_back(c);
    end
    drv(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("b2b_pulses", 64'(pulses.size()), 64'd4);
    t0 = 8;
    foreach (pulses[k]) begin
      check("b2b_when", 64'(pulses[k]), 64'(t0));
      t0 += 10;
    end
    repeat (12) begin @(posedge clk); #1; end

    for (int n = 0; n < 60; n++) rand_op(0, 32);
    for (int n = 0; n < 100; n++) rand_op(1, 8);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_div_iter.md
Name: mdu_div_iter

Overview:
- Parametrised multicycle radix-2 restoring divider for the EX stage, replacing the fixed 32-bit divider.
- Width is generic. Adds annul, a divide-by-zero flag and a busy indication.
- Signed and unsigned modes are selected per operation.
- EX drives start/operands and holds its stall request until ready_o; result_o feeds HI/LO writeback.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request a divide; sampled only in IDLE.
- signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
- opdata1_i  input  WIDTH  dividend; sampled with start_i.
- opdata2_i  input  WIDTH  divisor; sampled with start_i.
- annul_i  input  1  abort the current operation.
- result_o  output  2*WIDTH  {remainder, quotient}; remainder in upper half.
- ready_o  output  1  result valid; one-cycle pulse.
- busy_o  output  1  high while iterating (RUN).
- div_zero_o  output  1  last completed operation had divisor 0; valid with ready_o and held until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE; result_o=0, ready_o=0, busy_o=0, div_zero_o=0; all internal registers cleared. Reset mid-RUN aborts with no ready pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0 → capture operands and signed_i, clear div_zero_o.
  - If divisor==0 → next state DONE with result_o=0 and div_zero_o=1 (latency 1).
  - Otherwise load |dividend| and |divisor| (abs only when signed_i=1), clear the partial remainder and iteration counter, then go to RUN.
  - start_i with annul_i=1 in the same cycle is ignored; stay IDLE.
- RUN:
  - Exactly WIDTH iterations, one quotient bit per cycle, MSB first.
  - Each iteration: shift the {partial remainder, dividend} pair left one bit, trial-subtract the divisor using a (WIDTH+1)-bit difference. If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - The counter runs 0..WIDTH-1 and wraps only via a state change.
  - On the final iteration, apply sign correction and register result_o at the same edge entering DONE:
    - quotient negated iff signed_i and the dividend/divisor sign bits differ;
    - remainder negated iff signed_i and the dividend is negative.
  - All negation is two's complement modulo 2^WIDTH. MIN/-1 therefore yields quotient=MIN, remainder=0, with no flag.
  - annul_i=1 in any RUN cycle → IDLE next cycle; result_o and div_zero_o unchanged; no ready pulse.
  - start_i and operand inputs are ignored during RUN.
- DONE:
  - ready_o=1 for exactly this one cycle, then unconditionally IDLE.
  - start_i in DONE is ignored; a new operation needs start_i in IDLE, earliest one cycle after ready.
  - annul_i in DONE has no effect.
- Outputs:
  - busy_o = (state==RUN), registered.
  - ready_o = (state==DONE).
  - result_o holds its value from DONE until the next completed operation.
- Latency: start accepted at edge T → ready_o high in cycle T+WIDTH+1 for a nonzero divisor (33 cycles at WIDTH=32), T+1 for a zero divisor.
- Back-to-back: start held high continuously → one operation per WIDTH+2 cycles.

Test Plan:
- WIDTH=32, unsigned 100/7 → ready_o exactly 33 cycles after the start edge; result_o={32'd2, 32'd14}; busy_o high for 32 cycles; div_zero_o=0.
- WIDTH=32, signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned same operands → quotient 0, remainder 0x80000000.
- Divisor 0 with dividend 0x1234 → ready_o one cycle after start, result_o=0, div_zero_o=1. Next divide 9/3 → div_zero_o cleared at start; result {0, 3}.
- Complete 100/7, then start 50/5 and assert annul_i in RUN iteration 10 → IDLE next cycle, no ready_o, result_o still {2, 14}. Also assert async rst mid-RUN → all outputs 0 immediately.
- WIDTH=8 instance: unsigned 0xFF/0x10 → {0x0F, 0x0F}, ready 9 cycles after start. Signed 0x80/0xFF → {0x00, 0x80}. start_i held high → ready pulses every 10 cycles.
